// File: rtl/la_skidbuf.sv
// -----------------------------------------------------------------------------
// la_skidbuf
//   Two-entry valid/ready pipeline stage (skid buffer). Every output (data,
//   valid and ready) is taken from flops, so no combinational path runs from
//   the producer to the consumer or back. A downstream negedge capture flop
//   therefore sees a clean half-cycle flop-to-flop path. Under continuous flow
//   the stage moves one word per clock with no bubbles.
//
// Handshake: a word moves on a rising edge when valid and ready are both high
//   on that side (IN = in_valid & in_ready, OUT = out_valid & out_ready).
//   Once out_valid is high, out_valid and out_data hold until OUT occurs.
//   in_data is sampled only on IN.
//
// Ports
//   clk        in   1   clock, rising edge
//   nreset     in   1   asynchronous active-low reset
//   in_valid   in   1   producer has a word on in_data
//   in_ready   out  1   stage can take a word (state != FULL)
//   in_data    in   DW  producer word
//   out_valid  out  1   out_data holds a word (state != EMPTY)
//   out_ready  in   1   consumer takes the head word this cycle
//   out_data   out  DW  head word
//
// Parameters
//   PROP  implementation property string, no functional effect
//   DW    data width in bits (>= 1)
// -----------------------------------------------------------------------------
module la_skidbuf #(
    parameter       PROP = "DEFAULT",
    parameter int   DW   = 8
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] head_q, head_d;   // word presented on out_data
    logic [DW-1:0] skid_q, skid_d;   // overflow word caught when ready drops

    logic in_xfer;
    logic out_xfer;

    // PROP selects implementation variants elsewhere in the library; this
    // generic stage has none, so the reference produces no logic.
    if (PROP == "") begin : g_prop_none
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;

        // Registers load only on a real transfer, so in_data is never
        // looked at (and an X on it never leaks in) while in_valid is low.
        unique case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    state_d = ST_ONE;
                    head_d  = in_data;
                end
            end
            ST_ONE: begin
                if (in_xfer && out_xfer) begin
                    head_d = in_data;
                end else if (in_xfer) begin
                    state_d = ST_FULL;
                    skid_d  = in_data;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only the drain side can move.
                if (out_xfer) begin
                    state_d = ST_ONE;
                    head_d  = skid_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registered state only
    // ------------------------------------------------------------------
    always_comb begin
        out_valid = (state_q != ST_EMPTY);
        in_ready  = (state_q != ST_FULL);
    end

    assign out_data = head_q;

endmodule

// File: tb/tb_la_skidbuf.sv
// -----------------------------------------------------------------------------
// tb_la_skidbuf
//   Directed vector table for la_skidbuf plus hand-written sequences for
//   asynchronous reset, reset from FULL, and a long scoreboarded run.
// -----------------------------------------------------------------------------
module tb_la_skidbuf;

  localparam int DW         = 8;
  localparam int RND_WORDS  = 2000;
  localparam int RND_LIMIT  = 20000;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk    = 1'b0;
  logic clk_en = 1'b0;
  logic nreset = 1'b1;

  always #5 if (clk_en) clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUT
  // ---------------------------------------------------------------------------
  logic          in_valid  = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data   = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;

  la_skidbuf #(.PROP("DEFAULT"), .DW(DW)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard and counters
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          e_ov;
    logic          e_ir;
    logic [DW-1:0] e_od;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic iv, input logic [DW-1:0] d,
                              input logic ordy, input logic e_ov,
                              input logic e_ir, input logic [DW-1:0] e_od);
    vec_t v;
    v.iv   = iv;
    v.d    = d;
    v.ordy = ordy;
    v.e_ov = e_ov;
    v.e_ir = e_ir;
    v.e_od = e_od;
    vecs.push_back(v);
  endfunction

  // Drive at negedge, let one posedge happen, check just after it.
  task automatic apply_vec(input vec_t v, input int idx);
    string tag;
    @(negedge clk);
    in_valid  = v.iv;
    in_data   = v.d;
    out_ready = v.ordy;
    @(posedge clk);
    #1;
    tag = $sformatf("vec%0d", idx);
    check({tag, "_out_valid"}, DW'(out_valid), DW'(v.e_ov));
    check({tag, "_in_ready"},  DW'(in_ready),  DW'(v.e_ir));
    check({tag, "_out_data"},  out_data,       v.e_od);
  endtask

  task automatic drive_idle();
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [DW-1:0] xd;
    xd = 'x;

    // ---- Reset with the clock stopped ---------------------------------------
    drive_idle();
    #2 nreset = 1'b0;
    #2;
    check("rst_async_out_valid", DW'(out_valid), DW'(1'b0));
    check("rst_async_in_ready",  DW'(in_ready),  DW'(1'b1));
    check("rst_async_out_data",  out_data,       '0);

    // Edges while reset is low must not register a transfer.
    clk_en = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h5A;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_out_valid", DW'(out_valid), DW'(1'b0));
    check("rst_hold_out_data",  out_data,       '0);
    @(negedge clk);
    drive_idle();
    nreset = 1'b1;

    // ---- Vector table --------------------------------------------------------
    // Single word
    add(1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5);
    // Stream 1..16 with no bubbles, then drain
    for (int k = 1; k <= 16; k++) add(1'b1, DW'(k), 1'b1, 1'b1, 1'b1, DW'(k));
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h10);
    // Backpressure: fill, refuse 33, release, 33 taken after 22 leaves
    add(1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11);
    add(1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'h11);
    add(1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 8'h11);
    add(1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h22);
    add(1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h33);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33);
    // X on in_data while idle must not reach the head register
    add(1'b0, xd,    1'b0, 1'b0, 1'b1, 8'h33);
    add(1'b0, xd,    1'b1, 1'b0, 1'b1, 8'h33);
    // ONE with no handshake holds, X ignored, then drain
    add(1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 8'h44);
    add(1'b0, xd,    1'b0, 1'b1, 1'b1, 8'h44);
    add(1'b0, xd,    1'b0, 1'b1, 1'b1, 8'h44);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h44);
    // FULL with stalled consumer holds both words in order
    add(1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 8'h55);
    add(1'b1, 8'h66, 1'b0, 1'b1, 1'b0, 8'h55);
    add(1'b0, 8'h77, 1'b0, 1'b1, 1'b0, 8'h55);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h66);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h66);

    for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], i);

    // ---- Scoreboarded run with random handshakes -----------------------------
    begin
      int sent   = 0;
      int recv   = 0;
      int cycles = 0;
      logic iv, ordy;
      logic [DW-1:0] d;
      exp_q.delete();
      while (recv < RND_WORDS && cycles < RND_LIMIT) begin
        @(negedge clk);
        check("rnd_out_valid", DW'(out_valid), DW'(exp_q.size() > 0));
        check("rnd_in_ready",  DW'(in_ready),  DW'(exp_q.size() < 2));
        if (exp_q.size() > 0) check("rnd_out_data", out_data, exp_q[0]);
        iv   = (sent < RND_WORDS) && ($urandom_range(0, 1) == 1);
        ordy = ($urandom_range(0, 1) == 1);
        d    = iv ? DW'($urandom_range(0, 255)) : xd;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        @(posedge clk);
        begin
          logic in_x, out_x;
          in_x  = iv && (exp_q.size() < 2);
          out_x = ordy && (exp_q.size() > 0);
          if (out_x) begin
            void'(exp_q.pop_front());
            recv++;
          end
          if (in_x) begin
            exp_q.push_back(d);
            sent++;
          end
        end
        cycles++;
      end
      total++;
      if (recv < RND_WORDS) begin
        bad++;
        $display("FAIL rnd_timeout: got %0d words expected %0d", recv, RND_WORDS);
      end
      @(negedge clk);
      drive_idle();
      check("rnd_drained_out_valid", DW'(out_valid), DW'(1'b0));
    end

    // ---- Reset from FULL -----------------------------------------------------
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = 8'hAA;
    out_ready = 1'b0;
    @(negedge clk);
    in_data   = 8'hBB;
    @(posedge clk);
    #1;
    check("full_out_valid", DW'(out_valid), DW'(1'b1));
    check("full_in_ready",  DW'(in_ready),  DW'(1'b0));
    check("full_out_data",  out_data,       8'hAA);
    #1 nreset = 1'b0;
    #1;
    check("rst_full_out_valid", DW'(out_valid), DW'(1'b0));
    check("rst_full_in_ready",  DW'(in_ready),  DW'(1'b1));
    check("rst_full_out_data",  out_data,       '0);
    // An attempted transfer during reset is ignored.
    in_valid  = 1'b1;
    in_data   = 8'hCC;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rst_edge_out_valid", DW'(out_valid), DW'(1'b0));
    check("rst_edge_out_data",  out_data,       '0);
    // Release and offer DD for the very first edge after release.
    @(negedge clk);
    nreset    = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hDD;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_out_valid", DW'(out_valid), DW'(1'b1));
    check("post_rst_out_data",  out_data,       8'hDD);
    @(negedge clk);
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_drain_out_valid", DW'(out_valid), DW'(1'b0));
    check("post_rst_drain_out_data",  out_data,       8'hDD);
    @(posedge clk);
    #1;
    check("post_rst_no_stale_valid", DW'(out_valid), DW'(1'b0));
    check("post_rst_no_stale_data",  out_data,       8'hDD);

    // ---- Report --------------------------------------------------------------
    drive_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound in case a wait above never completes.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
